// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared constants and types for the PS/2 key event decoder.
// Set-2 prefix bytes, parser states and the queued event record.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_ERR1  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_SKIP
    } parse_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_event_t;

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Scancode input strobe plus the event-queue valid/ready output side.
// master drives bytes and ready; slave is the decoder.
interface ps2_key_event_decoder_if;

    logic [7:0] scancode;
    logic       valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic       ev_valid;
    logic       ev_ready;
    logic       overflow;

    modport master (
        output scancode, valid, ev_ready,
        input  ev_code, ev_ext, ev_release, ev_valid, overflow
    );

    modport slave (
        input  scancode, valid, ev_ready,
        output ev_code, ev_ext, ev_release, ev_valid, overflow
    );

endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// Show-ahead event FIFO; head is presented combinationally, zero when empty.
// Extra pointer bit distinguishes full from empty.
module key_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  key_event_t din,
    input  logic       pop,
    output key_event_t dout,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    key_event_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update and one-cycle drop indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            overflow <= push && !do_push;
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Folds set-2 prefix bytes (E0/F0/E1) into single key events.
// Events are queued for the display side through a valid/ready FIFO.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_key_event_decoder_if.slave  bus
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = $clog2(PAUSE_SKIP + 1);

    parse_state_t state, state_n;
    logic          ext, ext_n;
    logic          rel, rel_n;
    logic [SW-1:0] skip, skip_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          push;
    key_event_t    push_ev;
    key_event_t    head;
    logic          full;
    logic          empty;
    logic          pop;

    // Parser state, prefix flags and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            ext   <= 1'b0;
            rel   <= 1'b0;
            skip  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            ext   <= ext_n;
            rel   <= rel_n;
            skip  <= skip_n;
            tcnt  <= tcnt_n;
        end
    end

    // Next-state: a valid byte always wins over an expiring timeout.
    always_comb begin
        state_n = state;
        ext_n   = ext;
        rel_n   = rel;
        skip_n  = skip;
        tcnt_n  = tcnt;
        push    = 1'b0;
        push_ev = '{code: bus.scancode, ext: ext, rel: rel};
        unique case (state)
            ST_IDLE, ST_PREFIX: begin
                if (bus.valid) begin
                    tcnt_n = '0;
                    unique case (1'b1)
                        bus.scancode == PS2_EXT: begin
                            ext_n   = 1'b1;
                            state_n = ST_PREFIX;
                        end
                        bus.scancode == PS2_BRK: begin
                            rel_n   = 1'b1;
                            state_n = ST_PREFIX;
                        end
                        bus.scancode == PS2_PAUSE: begin
                            ext_n   = 1'b0;
                            rel_n   = 1'b0;
                            skip_n  = SW'(PAUSE_SKIP);
                            state_n = ST_SKIP;
                        end
                        bus.scancode == PS2_ERR0,
                        bus.scancode == PS2_ERR1: begin
                            ext_n   = 1'b0;
                            rel_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                        default: begin
                            push    = 1'b1;
                            ext_n   = 1'b0;
                            rel_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    endcase
                end else if (state == ST_PREFIX) begin
                    if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        ext_n   = 1'b0;
                        rel_n   = 1'b0;
                        tcnt_n  = '0;
                        state_n = ST_IDLE;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (bus.valid) begin
                    skip_n = skip - 1'b1;
                    if (skip <= SW'(1)) begin
                        skip_n  = '0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign pop = !empty && bus.ev_ready;

    key_event_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (push_ev),
        .pop      (pop),
        .dout     (head),
        .full     (full),
        .empty    (empty),
        .overflow (bus.overflow)
    );

    assign bus.ev_code    = head.code;
    assign bus.ev_ext     = head.ext;
    assign bus.ev_release = head.rel;
    assign bus.ev_valid   = !empty;

endmodule
